// File: rtl/pwm_pkg.sv
// Shared PWM constants: FSM state encoding plus counter/synchronizer defaults
// used by both the generator and the capture block.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF       = 17;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam logic [1:0] SEEK = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

endpackage

// File: rtl/pwm_cap_filter.sv
// Input conditioning for pwm_capture: synchronizer, optional deglitch
// (PWM_CAP_DEGLITCH_EN), and registered rise/fall detection.
module pwm_cap_filter
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
`ifdef PWM_CAP_DEGLITCH_EN
  , parameter int unsigned DEGLITCH_LEN = 4
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   level;
    logic                   prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync[SYNC_STAGES-1];

`ifdef PWM_CAP_DEGLITCH_EN
    localparam int unsigned RUN_W = (DEGLITCH_LEN > 1) ? $clog2(DEGLITCH_LEN) : 1;

    logic [RUN_W-1:0] run;
    logic             filt;

    // Level flips on the DEGLITCH_LEN-th consecutive differing sample; any
    // agreeing sample restarts the run, so short pulses never reach filt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt <= 1'b0;
            run  <= '0;
        end else if (sync_out == filt) begin
            run <= '0;
        end else if (run == RUN_W'(DEGLITCH_LEN - 1)) begin
            filt <= sync_out;
            run  <= '0;
        end else begin
            run <= run + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync_out;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            prev <= level;
            rise <= level & ~prev;
            fall <= ~level & prev;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with stuck-input timeout. Optional input
// deglitch is enabled by defining PWM_CAP_DEGLITCH_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
`ifdef PWM_CAP_DEGLITCH_EN
  , parameter int unsigned DEGLITCH_LEN = 4
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             stuck
);

    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;

    pwm_cap_filter #(
        .SYNC_STAGES  (SYNC_STAGES)
`ifdef PWM_CAP_DEGLITCH_EN
      , .DEGLITCH_LEN (DEGLITCH_LEN)
`endif
    ) u_filter (
        .CLK    (CLK),
        .RST    (RST),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= SEEK;
            cnt         <= '0;
            hi_lat      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                SEEK: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= HIGH;
                    end
                end
                HIGH, LOW: begin
                    // Saturation wins over any edge arriving in the same cycle.
                    if (cnt == '1) begin
                        meas_period <= '1;
                        meas_high   <= (state == HIGH) ? '1 : '0;
                        meas_valid  <= 1'b1;
                        stuck       <= 1'b1;
                        cnt         <= '0;
                        state       <= SEEK;
                    end else if (state == LOW && rise) begin
                        meas_period <= cnt;
                        meas_high   <= hi_lat;
                        meas_valid  <= 1'b1;
                        stuck       <= 1'b0;
                        cnt         <= CNT_W'(1);
                        state       <= HIGH;
                    end else begin
                        if (state == HIGH && fall) begin
                            hi_lat <= cnt;
                            state  <= LOW;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture, run at a reduced counter width so the
// timeout cases stay short; follows PWM_CAP_DEGLITCH_EN if defined.
module tb_pwm_capture;

    localparam int unsigned CW    = 12;
    localparam int unsigned SS    = 2;
    localparam int unsigned MAXC  = (32'd1 << CW) - 32'd1;
`ifdef PWM_CAP_DEGLITCH_EN
    localparam int unsigned DL    = 4;
    localparam int unsigned FLAT  = DL;
    localparam int unsigned PW    = DL;
`else
    localparam int unsigned FLAT  = 0;
    localparam int unsigned PW    = 1;
`endif

    typedef struct {
        int unsigned p;
        int unsigned h;
        int unsigned s;
        int unsigned at;
    } rec_t;

    logic          CLK    = 1'b0;
    logic          RST    = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] meas_period;
    logic [CW-1:0] meas_high;
    logic          meas_valid;
    logic          stuck;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned rise_k = 0;
    int unsigned n_before = 0;
    rec_t        got_q[$];
    rec_t        exp_q[$];

    pwm_capture #(
        .CNT_W        (CW),
        .SYNC_STAGES  (SS)
`ifdef PWM_CAP_DEGLITCH_EN
      , .DEGLITCH_LEN (DL)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pwm_in      (pwm_in),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_valid  (meas_valid),
        .stuck       (stuck)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin : mon
        rec_t r;
        if (meas_valid === 1'b1) begin
            r.p  = 32'(meas_period);
            r.h  = 32'(meas_high);
            r.s  = 32'(stuck);
            r.at = cyc;
            got_q.push_back(r);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int unsigned n);
        pwm_in = lvl;
        repeat (n) @(negedge CLK);
    endtask

    task automatic exp_push(input int unsigned p, input int unsigned h, input int unsigned s);
        rec_t r;
        r.p  = p;
        r.h  = h;
        r.s  = s;
        r.at = 0;
        exp_q.push_back(r);
    endtask

    initial begin
        RST    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_period", 32'(meas_period), 32'd0);
        chk("rst_high",   32'(meas_high),   32'd0);
        chk("rst_valid",  32'(meas_valid),  32'd0);
        chk("rst_stuck",  32'(stuck),       32'd0);

        // Long period: first publish only on the second rise
        hold(1'b1, 256);
        hold(1'b0, 3744);
        rise_k = cyc + 1;
        hold(1'b1, 256);
        hold(1'b0, 3744);
        exp_push(4000, 256, 0);
        exp_push(4000, 256, 0);

        // Duty sweep at period 1000
        for (int unsigned h = 100; h <= 900; h += 100) begin
            hold(1'b1, h);
            hold(1'b0, 1000 - h);
            exp_push(1000, h, 0);
        end

        // Stuck high, then recovery at 500/100
        hold(1'b1, 6000);
        exp_push(MAXC, MAXC, 1);
        chk("stuck_hi_live", 32'(stuck), 32'd1);
        hold(1'b0, 400);
        hold(1'b1, 100);
        hold(1'b0, 400);
        hold(1'b1, 100);
        exp_push(500, 100, 0);
        chk("recover_stuck_live", 32'(stuck), 32'd0);

        // Stuck low
        hold(1'b0, 5000);
        exp_push(MAXC, 0, 1);
        chk("stuck_lo_live",   32'(stuck),       32'd1);
        chk("stuck_lo_high",   32'(meas_high),   32'd0);
        chk("stuck_lo_period", 32'(meas_period), MAXC);

        // Minimum-width pulses every 10 clocks
        repeat (5) begin
            hold(1'b1, PW);
            hold(1'b0, 10 - PW);
        end
        exp_push(10, PW, 0);
        exp_push(10, PW, 0);
        exp_push(10, PW, 0);
        exp_push(10, PW, 0);

        // 2-clock low glitch inside a 300-clock high
        hold(1'b1, 150);
        exp_push(10, PW, 0);
        hold(1'b0, 2);
`ifndef PWM_CAP_DEGLITCH_EN
        exp_push(152, 150, 0);
`endif
        hold(1'b1, 148);
        hold(1'b0, 200);
        hold(1'b1, 50);
`ifdef PWM_CAP_DEGLITCH_EN
        exp_push(500, 300, 0);
`else
        exp_push(348, 148, 0);
`endif

        // Reset while in HIGH
        RST    = 1'b1;
        pwm_in = 1'b0;
        @(negedge CLK);
        chk("midrst_period", 32'(meas_period), 32'd0);
        chk("midrst_high",   32'(meas_high),   32'd0);
        chk("midrst_valid",  32'(meas_valid),  32'd0);
        chk("midrst_stuck",  32'(stuck),       32'd0);
        RST = 1'b0;
        n_before = got_q.size();
        hold(1'b0, 100);
        hold(1'b1, 50);
        hold(1'b0, 100);
        chk("midrst_no_first_pub", got_q.size(), n_before);
        hold(1'b1, 50);
        hold(1'b0, 20);
        exp_push(150, 50, 0);

        chk("strobe_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("s%0d_period", i), got_q[i].p, exp_q[i].p);
            chk($sformatf("s%0d_high", i),   got_q[i].h, exp_q[i].h);
            chk($sformatf("s%0d_stuck", i),  got_q[i].s, exp_q[i].s);
        end
        if (got_q.size() > 0)
            chk("first_latency", got_q[0].at, rise_k + SS + 1 + FLAT);
        else
            chk("first_latency_missing", 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
